seg8_scan: RTL
==============

Name: seg8_scan

Overview:
Downstream consumer of the 32-bit LFSR word. It drives a multiplexed 8-digit seven-segment display.
- Latches a 32-bit value (8 hex nibbles) plus a decimal-point mask.
- Scans the digits one at a time with a per-digit dwell and an anti-ghosting guard interval.
- Applies new data only at frame boundaries, so the display never tears.
- Emits a one-clock frame pulse, usable as the LFSR enable, so one new pseudo-random word is shown per frame.

Parameters:
- DWELL, 1024, clocks each digit is selected (>= GUARD+2).
- GUARD, 16, clocks at the start of each dwell slot with all digits off.
- SEG_ACTIVE_LOW, 1, when 1, o_seg and o_dp are inverted (lit = 0).
- DIG_ACTIVE_LOW, 1, when 1, o_dig is inverted (selected = 0).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_data  in  32  value to display; nibble k goes to digit k, digit 0 is rightmost.
- i_dp  in  8  decimal-point mask, bit k lights the dp of digit k.
- i_load  in  1  single-cycle strobe; captures i_data and i_dp.
- i_blank_lz  in  1  leading-zero blanking enable; sampled live.
- o_seg  out  7  segments, bit0=a … bit6=g.
- o_dp  out  1  decimal point of the selected digit.
- o_dig  out  8  digit selects, one-hot when active.
- o_frame  out  1  one-clock pulse per completed frame.
- o_pending  out  1  a loaded value is waiting for the frame boundary.

Behaviour:
- Reset (async, rst_n=0): prescaler cnt=0, digit idx=0, disp=0, dp_disp=0, pend=0, pend_dp=0, o_pending=0, o_frame=0.
  - o_seg/o_dp in unlit state (7'h7F / 1 when active-low).
  - o_dig all deselected (8'hFF when active-low).
  - Reset mid-frame takes effect immediately and the scan restarts at idx 0, cnt 0.
- Prescaler: cnt counts 0..DWELL-1. At cnt==DWELL-1: cnt→0 and idx→idx+1 mod 8 (7 wraps to 0).
- Boundary cycle (B): the cycle with cnt==DWELL-1 and idx==7.
- Guard: while cnt<GUARD, o_dig is all deselected and segments are unlit.
- Active slot (cnt>=GUARD):
  - Digit idx is selected.
  - o_seg = decode(disp[4*idx+3:4*idx]).
  - o_dp = dp_disp[idx].
- Output timing: all display outputs are registered, with one-clock latency from (cnt, idx). On the first cycle after reset release they are still inactive.
- Hex decode (gfedcba, lit=1): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Output is inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking: when i_blank_lz=1, a digit k>0 is blanked if every nibble k..7 of disp is zero. Blanking means o_dig is deselected for that slot and segments are unlit; the dp is blanked too. Digit 0 is never blanked.
- Load:
  - i_load on a non-B cycle: pend<=i_data, pend_dp<=i_dp, o_pending<=1. A later load before B overwrites the earlier one (last wins).
  - On B with o_pending=1 and no i_load: disp<=pend, dp_disp<=pend_dp, o_pending<=0.
  - On B with i_load=1: disp<=i_data, dp_disp<=i_dp (bypass), o_pending<=0.
  - On B with neither: disp is unchanged.
  - The new disp first appears in the digit-0 slot of the next frame.
- o_frame: registered; high for exactly the one cycle after B, every frame, regardless of whether a load occurred. Frame period is 8*DWELL clocks.
- Widths:
  - cnt is $clog2(DWELL) bits and idx is 3 bits.
  - No overflow is possible; a DWELL that is not a power of two is handled by the explicit compare.

Decomposition:
- Shared package seg8_pkg holds:
  - the 16-entry hex→segment constant table;
  - the segment bit-order constants;
  - the NUM_DIGITS=8 constant.
- One sub-module: hex7seg_dec, a combinational 4→7 decoder using the package table. Polarity inversion stays in seg8_scan.

Test Plan (DWELL=8, GUARD=2, both active-low):
- Reset: hold rst_n=0 → o_dig=FF, o_seg=7F, o_dp=1, o_frame=0, o_pending=0. Release rst_n → first 3 cycles keep o_dig=FF.
- Load mid-frame: i_load with 32'h89ABCDEF, i_dp=8'h01 at idx 3 → o_pending=1 and the display still shows 0s. After B: o_frame pulses once and o_pending=0. Next digit-0 slot: o_dig=FE, o_seg=0E (F), o_dp=0. Digit 7 then shows 8 (o_seg=00).
- Guard/scan: over one frame, each o_dig pattern FE,FD,…,7F is seen for exactly 6 cycles, separated by 2 cycles of FF. o_frame period is 64 clocks.
- Leading-zero blanking: load 32'h00000050 with i_blank_lz=1 → digit0 o_seg=40 (0), digit1 o_seg=12 (5), digits 2–7 o_dig=FF. With i_blank_lz=0, digits 2–7 show 40.
- Load on B: i_load with 32'h12345678 exactly on B while an older value is pending → displayed value is 12345678, o_pending=0 after B.
- Async reset mid-slot: drop rst_n at idx 5, cnt 4 → outputs go inactive within the same cycle, without waiting for a clock edge. After release, the scan restarts at digit 0 and disp=0.

Source files
------------

// File: rtl/seg8_pkg.sv
// Shared constants for the 8-digit seven-segment scanner: hex glyph table,
// segment bit order and digit count.
package seg8_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment bit order inside a glyph: bit0 = a ... bit6 = g.
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;

    // Lit-high glyphs (gfedcba), indexed by nibble value; entry 15 is leftmost.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex7_lookup(input logic [3:0] nib);
        return HEX7_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg8_scan_hex7seg_dec.sv
// Combinational hex nibble to seven-segment glyph decoder (lit = 1).
// Output polarity is handled by the instantiating scanner.
module hex7seg_dec
    import seg8_pkg::*;
(
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg
);

    // Table lookup of the lit-high glyph.
    always_comb begin
        o_seg = '0;
        o_seg[SEG_G:SEG_A] = hex7_lookup(i_nib);
    end

endmodule

// File: rtl/seg8_scan.sv
// Multiplexed 8-digit seven-segment scanner with per-digit dwell, guard
// blanking, leading-zero suppression and tear-free frame-boundary updates.
module seg8_scan
    import seg8_pkg::*;
#(
    parameter int DWELL          = 1024,
    parameter int GUARD          = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           i_data,
    input  logic [NUM_DIGITS-1:0] i_dp,
    input  logic                  i_load,
    input  logic                  i_blank_lz,
    output logic [SEG_W-1:0]      o_seg,
    output logic                  o_dp,
    output logic [NUM_DIGITS-1:0] o_dig,
    output logic                  o_frame,
    output logic                  o_pending
);

    localparam int                    CW        = $clog2(DWELL);
    localparam logic [CW-1:0]         CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0]         CNT_GUARD = CW'(GUARD);
    localparam logic                  SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic                  DIG_INV   = (DIG_ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0]      SEG_OFF   = {SEG_W{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_INV}};

    logic [CW-1:0]           r_cnt;
    logic [2:0]              r_idx;
    logic [31:0]             r_disp;
    logic [NUM_DIGITS-1:0]   r_dp_disp;
    logic [31:0]             r_pend;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pending;
    logic                    r_frame;
    logic [SEG_W-1:0]        r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig;

    logic                    w_last;
    logic                    w_bound;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic                    w_blank;
    logic                    w_lit;
    logic [3:0]              w_nib;
    logic [SEG_W-1:0]        w_glyph;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [SEG_W-1:0]        w_seg_nxt;
    logic                    w_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_dig_nxt;

    assign w_last   = (r_cnt == CNT_LAST);
    assign w_bound  = w_last && (r_idx == 3'd7);
    assign w_nib    = r_disp[{r_idx, 2'b00} +: 4];
    assign w_onehot = 8'b0000_0001 << r_idx;

    hex7seg_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // Flag, per digit, whether that nibble and every more-significant one is zero.
    always_comb begin : lz_scan
        logic v_run;
        v_run        = 1'b1;
        w_upper_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_run           = v_run && (r_disp[4*k +: 4] == 4'h0);
            w_upper_zero[k] = v_run;
        end
    end

    // Decide whether the current slot is lit and form the next output pattern.
    always_comb begin
        w_blank = i_blank_lz && (r_idx != 3'd0) && w_upper_zero[r_idx];
        w_lit   = (r_cnt >= CNT_GUARD) && !w_blank;
        if (w_lit) begin
            w_seg_nxt = w_glyph ^ SEG_OFF;
            w_dp_nxt  = r_dp_disp[r_idx] ^ SEG_INV;
            w_dig_nxt = w_onehot ^ DIG_OFF;
        end else begin
            w_seg_nxt = SEG_OFF;
            w_dp_nxt  = SEG_INV;
            w_dig_nxt = DIG_OFF;
        end
    end

    // Dwell prescaler and digit index; idx wraps 7 -> 0 by its 3-bit width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Pending capture and frame-boundary transfer; a load on the boundary bypasses pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp    <= 32'h0000_0000;
            r_dp_disp <= 8'h00;
            r_pend    <= 32'h0000_0000;
            r_pend_dp <= 8'h00;
            r_pending <= 1'b0;
        end else if (i_load) begin
            if (w_bound) begin
                r_disp    <= i_data;
                r_dp_disp <= i_dp;
                r_pending <= 1'b0;
            end else begin
                r_pend    <= i_data;
                r_pend_dp <= i_dp;
                r_pending <= 1'b1;
            end
        end else if (w_bound && r_pending) begin
            r_disp    <= r_pend;
            r_dp_disp <= r_pend_dp;
            r_pending <= 1'b0;
        end
    end

    // Registered display outputs and frame pulse, one clock behind (cnt, idx).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= SEG_OFF;
            r_dp    <= SEG_INV;
            r_dig   <= DIG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
            r_dig   <= w_dig_nxt;
            r_frame <= w_bound;
        end
    end

    assign o_seg     = r_seg;
    assign o_dp      = r_dp;
    assign o_dig     = r_dig;
    assign o_frame   = r_frame;
    assign o_pending = r_pending;

endmodule
